// File: rtl/t08_imem_fetch_handler.sv
// Instruction-fetch handler: turns the PC into one bus read at a time, freezes the PC stage
// while the read is outstanding and registers the word for decode. Optional: T08_IMEM_REUSE_EN.
module t08_imem_fetch_handler #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] pc,
  input  logic        data_stall,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        freeze,
  output logic        fetch_err,
  output logic [1:0]  fsm_state
);

  // Handshake: bus_req is held until a one-cycle bus_ack; bus_ack counts only in WAIT,
  // where bus_rdata is captured in the same cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(ACK_TIMEOUT);

  state_t     state;
  logic [7:0] ack_cnt;
  logic       timeout;
  logic       tag_hit;

  // ack_cnt is 0 in the first WAIT cycle; the cycle in which it equals ACK_TIMEOUT
  // with no ack is the timeout cycle. An ack in that cycle still wins.
  assign timeout = (state == WAIT) && !bus_ack && (ack_cnt == TIMEOUT_VAL);

`ifdef T08_IMEM_REUSE_EN
  logic [31:0] tag;
  logic        tag_valid;

  assign tag_hit = tag_valid && (pc == tag);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tag       <= '0;
      tag_valid <= 1'b0;
    end else if (state == WAIT && bus_ack) begin
      tag       <= pc;
      tag_valid <= 1'b1;
    end
  end
`else
  assign tag_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      ack_cnt <= '0;
      instr   <= '0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (tag_hit) begin
            state <= DELIVER;
          end else if (!data_stall) begin
            state   <= WAIT;
            ack_cnt <= '0;
          end
        end
        WAIT: begin
          if (bus_ack) begin
            instr <= bus_rdata;
            state <= DELIVER;
          end else if (ack_cnt == TIMEOUT_VAL) begin
            state <= REQ;
          end else begin
            ack_cnt <= ack_cnt + 8'd1;
          end
        end
        DELIVER: begin
          if (!data_stall) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus_req     = 1'b0;
    freeze      = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE: freeze = 1'b0;
      REQ: begin
        freeze  = 1'b1;
        bus_req = !data_stall && !tag_hit;
      end
      WAIT: begin
        freeze  = 1'b1;
        bus_req = !timeout;
      end
      DELIVER: begin
        // A data access holding the bus also delays the commit cycle.
        freeze      = data_stall;
        instr_valid = 1'b1;
      end
      default: freeze = 1'b0;
    endcase
  end

  assign bus_addr  = pc;
  assign fetch_err = timeout;
  assign fsm_state = state;

endmodule

// File: tb/tb_t08_imem_fetch_handler.sv
// Bench for t08_imem_fetch_handler: PC-stage model, directed bus-slave driver and a
// delivery scoreboard. Build with T08_IMEM_REUSE_EN defined to exercise the reuse path.
module tb_t08_imem_fetch_handler;

  logic        clk;
  logic        nrst;
  logic [31:0] pc;
  logic        data_stall;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        freeze;
  logic        fetch_err;
  logic [1:0]  fsm_state;

  logic        jump_en;
  logic [31:0] jump_tgt;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  t08_imem_fetch_handler #(.ACK_TIMEOUT(3)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .pc          (pc),
    .data_stall  (data_stall),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .bus_req     (bus_req),
    .bus_addr    (bus_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .freeze      (freeze),
    .fetch_err   (fetch_err),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC stage: steps (or jumps) whenever it is not frozen
  always @(posedge clk or negedge nrst) begin
    if (!nrst) pc <= 32'hFFFF_FFFC;
    else if (!freeze) pc <= jump_en ? jump_tgt : pc + 32'd4;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // scoreboard monitor: one pop per delivery, instr held while instr_valid stays high
  logic        mon_prev_valid = 1'b0;
  logic [31:0] mon_held = '0;
  logic [63:0] mon_e;
  always @(negedge clk) begin
    #2;
    if (!nrst) begin
      mon_prev_valid = 1'b0;
    end else begin
      if (instr_valid && !mon_prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: instr %h addr %h with no expected entry", instr, bus_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("deliver_instr", instr, mon_e[31:0]);
          chk("deliver_addr", bus_addr, mon_e[63:32]);
        end
      end else if (instr_valid && mon_prev_valid) begin
        chk("hold_instr", instr, mon_held);
      end
      if (instr_valid) chk("deliver_no_req", {31'd0, bus_req}, 32'd0);
      mon_held       = instr;
      mon_prev_valid = instr_valid;
    end
  end

  // driver tasks: each leaves the bench 1 time unit after a falling edge
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input int lat, input logic [31:0] data, input logic [31:0] addr,
                       input logic wait_stall, input logic deliver_stall, output int gap);
    gap = 0;
    while (bus_req !== 1'b1) begin
      if (gap >= 40) begin
        chk("req_wait_expired", {31'd0, bus_req}, 32'd1);
        return;
      end
      next_cycle();
      gap++;
    end
    chk("req_addr", bus_addr, addr);
    chk("req_freeze", {31'd0, freeze}, 32'd1);
    exp_q.push_back({addr, data});
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      data_stall = wait_stall;
      bus_ack    = (i == lat);
      bus_rdata  = (i == lat) ? data : $urandom;
      #1;
      chk("wait_req", {31'd0, bus_req}, 32'd1);
      chk("wait_addr", bus_addr, addr);
      chk("wait_freeze", {31'd0, freeze}, 32'd1);
      chk("wait_err", {31'd0, fetch_err}, 32'd0);
    end
    @(negedge clk);
    bus_ack    = 1'b0;
    bus_rdata  = $urandom;
    data_stall = deliver_stall;
    #1;
    chk("deliver_valid", {31'd0, instr_valid}, 32'd1);
    chk("deliver_freeze", {31'd0, freeze}, {31'd0, deliver_stall});
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  int gap;
  initial begin
    nrst = 1'b0; data_stall = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    jump_en = 1'b0; jump_tgt = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", {30'd0, fsm_state}, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_addr", bus_addr, 32'hFFFF_FFFC);

    // first fetch after reset: one unfrozen IDLE cycle wraps the PC to 0
    @(negedge clk); nrst = 1'b1; #1;
    chk("idle_freeze", {31'd0, freeze}, 32'd0);
    chk("idle_req", {31'd0, bus_req}, 32'd0);
    fetch(1, 32'h0000_0013, 32'h0000_0000, 1'b0, 1'b0, gap);
    chk("first_idle_cycles", gap, 32'd1);

    // ack after 4 cycles, with data_stall raised while the request is granted;
    // with ACK_TIMEOUT=3 that ack lands in the timeout cycle and must win
    fetch(4, 32'h00a0_0093, 32'h0000_0004, 1'b1, 1'b0, gap);
    chk("lat4_gap", gap, 32'd1);

    // data_stall: 2 cycles in REQ, then 3 cycles in DELIVER
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); data_stall = 1'b1; #1;
      chk("req_stall_req", {31'd0, bus_req}, 32'd0);
      chk("req_stall_addr", bus_addr, 32'h0000_0008);
      chk("req_stall_freeze", {31'd0, freeze}, 32'd1);
    end
    @(negedge clk); data_stall = 1'b0; #1;
    fetch(1, 32'h0010_8113, 32'h0000_0008, 1'b0, 1'b1, gap);
    chk("stall_gap", gap, 32'd0);
    chk("dstall_pc0", pc, 32'h0000_0008);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      chk("dstall_valid", {31'd0, instr_valid}, 32'd1);
      chk("dstall_freeze", {31'd0, freeze}, 32'd1);
      chk("dstall_instr", instr, 32'h0010_8113);
      chk("dstall_pc", pc, 32'h0000_0008);
    end
    @(negedge clk); data_stall = 1'b0; #1;
    chk("release_freeze", {31'd0, freeze}, 32'd0);
    chk("release_valid", {31'd0, instr_valid}, 32'd1);
    chk("release_pc", pc, 32'h0000_0008);
    next_cycle();
    chk("pc_advance", pc, 32'h0000_000C);
    chk("to_req_start", {31'd0, bus_req}, 32'd1);

    // timeout: three unacked WAIT cycles, then the timeout cycle, then a retry
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk("to_wait_req", {31'd0, bus_req}, 32'd1);
      chk("to_wait_err", {31'd0, fetch_err}, 32'd0);
    end
    next_cycle();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_req_gap", {31'd0, bus_req}, 32'd0);
    chk("to_freeze", {31'd0, freeze}, 32'd1);
    chk("to_valid", {31'd0, instr_valid}, 32'd0);
    next_cycle();
    chk("retry_err", {31'd0, fetch_err}, 32'd0);
    chk("retry_req", {31'd0, bus_req}, 32'd1);
    chk("retry_addr", bus_addr, 32'h0000_000C);
    fetch(2, 32'h0031_0193, 32'h0000_000C, 1'b0, 1'b0, gap);
    chk("retry_gap", gap, 32'd0);

    // reset in the middle of WAIT, then a late ack
    next_cycle();
    chk("mid_req_addr", bus_addr, 32'h0000_0010);
    next_cycle();
    chk("mid_wait_req", {31'd0, bus_req}, 32'd1);
    #2; nrst = 1'b0; #1;
    chk("async_req_drop", {31'd0, bus_req}, 32'd0);
    chk("async_instr", instr, 32'd0);
    chk("async_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
    @(negedge clk); nrst = 1'b1; #1;
    chk("late_ack_instr", instr, 32'd0);
    chk("late_ack_req", {31'd0, bus_req}, 32'd0);
    @(negedge clk); bus_ack = 1'b0; #1;
    chk("post_rst_instr", instr, 32'd0);
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    fetch(1, 32'h0000_0093, 32'h0000_0000, 1'b0, 1'b0, gap);
    chk("post_rst_gap", gap, 32'd0);

    // jump-to-self loop at 0x40
    jump_en  = 1'b1;
    jump_tgt = 32'h0000_0040;
    fetch(1, 32'h0000_006F, 32'h0000_0040, 1'b0, 1'b0, gap);
`ifdef T08_IMEM_REUSE_EN
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      exp_q.push_back({32'h0000_0040, 32'h0000_006F});
      chk("hit_req", {31'd0, bus_req}, 32'd0);
      chk("hit_req_valid", {31'd0, instr_valid}, 32'd0);
      chk("hit_req_freeze", {31'd0, freeze}, 32'd1);
      next_cycle();
      chk("hit_valid", {31'd0, instr_valid}, 32'd1);
      chk("hit_bus_req", {31'd0, bus_req}, 32'd0);
      chk("hit_freeze", {31'd0, freeze}, 32'd0);
    end
`else
    for (int i = 0; i < 2; i++) begin
      fetch(1, 32'h0000_006F, 32'h0000_0040, 1'b0, 1'b0, gap);
      chk("loop_refetch_gap", gap, 32'd1);
    end
`endif

    #2;
    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
